// File: rtl/lmg_move_collector.sv
// Collects per-column candidate move beats from the cell array, serializes set
// entries into a show-ahead move FIFO and counts moves for each board scan.
module lmg_move_collector #(
  parameter int unsigned MOVE_W     = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  col_valid,
  output logic                  col_ready,
  input  logic [7:0]            col_mask,
  input  logic [8*MOVE_W-1:0]   col_moves,
  input  logic                  col_last,
  output logic                  mv_valid,
  input  logic                  mv_ready,
  output logic [MOVE_W-1:0]     mv_data,
  output logic [CNT_W-1:0]      move_count,
  output logic                  scan_done,
  output logic                  overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCEPT    = 3'd1,
    SERIALIZE = 3'd2,
    FLUSH     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state;
  logic [MOVE_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [LVL_W-1:0]    level_nxt;
  logic [7:0]          mask_q;
  logic [8*MOVE_W-1:0] moves_q;
  logic                last_q;
  logic [MOVE_W-1:0]   sel_move;
  logic [7:0]          mask_rest;
  logic                fifo_full;
  logic                push;
  logic                pop;

  // Entry at the lowest set bit of the latched mask.
  always_comb begin
    sel_move = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) sel_move = moves_q[i*MOVE_W +: MOVE_W];
    end
  end

  // Fullness is judged on the start-of-cycle level, so a pop never frees a slot early.
  assign mask_rest = mask_q & (mask_q - 8'd1);
  assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
  assign push      = (state == SERIALIZE) && (mask_q != 8'd0) && !fifo_full;
  assign pop       = mv_valid && mv_ready;
  assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);
  assign mv_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col_ready  <= 1'b0;
      mv_valid   <= 1'b0;
      move_count <= '0;
      scan_done  <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      mask_q     <= '0;
      moves_q    <= '0;
      last_q     <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (start) begin
      // Fresh scan from any state; an in-flight scan is dropped without scan_done.
      state      <= ACCEPT;
      col_ready  <= 1'b1;
      mv_valid   <= 1'b0;
      move_count <= '0;
      scan_done  <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      level     <= level_nxt;
      mv_valid  <= (level_nxt != '0);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) begin
        mem[wr_ptr] <= sel_move;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        mask_q      <= mask_rest;
        if (move_count == CNT_MAX) overflow <= 1'b1;
        else                       move_count <= move_count + CNT_W'(1);
      end

      unique case (state)
        IDLE: ;
        ACCEPT: begin
          if (col_valid) begin
            mask_q  <= col_mask;
            moves_q <= col_moves;
            last_q  <= col_last;
            if (col_mask != 8'd0) begin
              state     <= SERIALIZE;
              col_ready <= 1'b0;
            end else if (col_last) begin
              state     <= FLUSH;
              col_ready <= 1'b0;
            end
          end
        end
        SERIALIZE: begin
          if (push && (mask_rest == 8'd0)) begin
            if (last_q) begin
              state <= FLUSH;
            end else begin
              state     <= ACCEPT;
              col_ready <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (level == '0) begin
            state     <= DONE;
            scan_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lmg_move_collector.sv
// Bench for lmg_move_collector: vector table, hand-timed corner sequences and
// randomized scans checked against a queue-based move model.
module tb_lmg_move_collector;

  localparam int unsigned MOVE_W = 12;
  localparam int unsigned CNT_W  = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                col_valid;
  logic                col_ready;
  logic [7:0]          col_mask;
  logic [8*MOVE_W-1:0] col_moves;
  logic                col_last;
  logic                mv_valid;
  logic                mv_ready;
  logic [MOVE_W-1:0]   mv_data;
  logic [CNT_W-1:0]    move_count;
  logic                scan_done;
  logic                overflow;

  lmg_move_collector dut (
    .clk(clk), .reset(reset), .start(start), .col_valid(col_valid),
    .col_ready(col_ready), .col_mask(col_mask), .col_moves(col_moves),
    .col_last(col_last), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_data(mv_data), .move_count(move_count), .scan_done(scan_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int n_pops = 0;
  int total = 0;
  bit rand_ready = 1'b0;
  bit ready_fixed = 1'b0;
  bit hold_prev = 1'b0;
  logic [MOVE_W-1:0] hold_data;
  logic [MOVE_W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] mask;
    int         exp_count;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_count();
    return (total > 255) ? 255 : total;
  endfunction

  function automatic logic [8*MOVE_W-1:0] rnd_moves();
    logic [8*MOVE_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*MOVE_W +: MOVE_W] = MOVE_W'($urandom);
    return r;
  endfunction

  // Consumer-side ready: either fixed or randomized per cycle.
  initial begin
    mv_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      mv_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Output monitor: ordering, stability under backpressure, pulse counting.
  initial begin
    logic [MOVE_W-1:0] e;
    forever begin
      @(negedge clk);
      if (scan_done === 1'b1) done_cnt++;
      if (mv_valid === 1'b1) valid_cnt++;
      if (hold_prev) begin
        chk("hold_valid", 32'(mv_valid), 32'(1));
        chk("hold_data", 32'(mv_data), 32'(hold_data));
      end
      hold_prev = (mv_valid === 1'b1) && !mv_ready && !start && !reset;
      hold_data = mv_data;
      if ((mv_valid === 1'b1) && mv_ready && !start && !reset) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          chk("unexpected_move", 32'(mv_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("mv_data", 32'(mv_data), 32'(e));
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.delete();
    total = 0;
  endtask

  // Returns one cycle after the accepting edge.
  task automatic send_beat(input logic [7:0] m, input logic [8*MOVE_W-1:0] mv, input bit last);
    int t = 0;
    col_mask = m; col_moves = mv; col_last = last; col_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!col_ready && t < 500);
    if (!col_ready) begin
      fail_to("beat_accept");
      col_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        exp_q.push_back(mv[i*MOVE_W +: MOVE_W]);
        total++;
      end
    end
    tick();
    col_valid = 1'b0; col_mask = '0; col_last = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!col_ready && t < 500) begin tick(); t++; end
    if (!col_ready) fail_to("col_ready");
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < budget) begin tick(); t++; end
    if (done_cnt == d0) fail_to("scan_done");
    else begin
      tick(); tick();
      chk("done_pulses", 32'(done_cnt - d0), 32'(1));
    end
    chk("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col_ready"}, 32'(col_ready), 32'(0));
    chk({tag, "_mv_valid"}, 32'(mv_valid), 32'(0));
    chk({tag, "_mv_data"}, 32'(mv_data), 32'(0));
    chk({tag, "_move_count"}, 32'(move_count), 32'(0));
    chk({tag, "_scan_done"}, 32'(scan_done), 32'(0));
    chk({tag, "_overflow"}, 32'(overflow), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl[6];
    logic [8*MOVE_W-1:0] mv;
    int d0, p0, v0;

    tbl[0] = '{mask: 8'h01, exp_count: 1};
    tbl[1] = '{mask: 8'h80, exp_count: 1};
    tbl[2] = '{mask: 8'h05, exp_count: 2};
    tbl[3] = '{mask: 8'hFF, exp_count: 8};
    tbl[4] = '{mask: 8'h00, exp_count: 0};
    tbl[5] = '{mask: 8'hA5, exp_count: 4};

    reset = 1'b1; start = 1'b0; col_valid = 1'b0; col_mask = '0;
    col_moves = '0; col_last = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_reset_vals("rst");

    // Vector table: single-beat scans
    ready_fixed = 1'b1;
    for (int v = 0; v < 6; v++) begin
      do_start();
      send_beat(tbl[v].mask, rnd_moves(), 1'b1);
      wait_done(200);
      chk("tbl_count", 32'(move_count), 32'(tbl[v].exp_count));
      chk("tbl_overflow", 32'(overflow), 32'(0));
    end

    // Single beat with exact timing
    ready_fixed = 1'b0;
    tick();
    do_start();
    mv = rnd_moves();
    mv[0 +: MOVE_W] = 12'h0A1;
    mv[2*MOVE_W +: MOVE_W] = 12'h0B2;
    send_beat(8'b0000_0101, mv, 1'b1);
    chk("sb_valid_e0", 32'(mv_valid), 32'(0));
    chk("sb_ready_e0", 32'(col_ready), 32'(0));
    tick();
    chk("sb_valid_e1", 32'(mv_valid), 32'(1));
    chk("sb_data_e1", 32'(mv_data), 32'h0A1);
    tick();
    chk("sb_data_e2", 32'(mv_data), 32'h0A1);
    ready_fixed = 1'b1;
    wait_done(100);
    chk("sb_count", 32'(move_count), 32'(2));

    // Full scan: 8 x 0xFF, col_ready low for 8 cycles per beat
    do_start();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 8; i++) mv[i*MOVE_W +: MOVE_W] = MOVE_W'(12'h100 + b*8 + i);
      send_beat(8'hFF, mv, b == 7);
      chk("fs_ready_low", 32'(col_ready), 32'(0));
      for (int j = 1; j < 8; j++) begin
        tick();
        if (j == 7) chk("fs_ready_low7", 32'(col_ready), 32'(0));
      end
      tick();
      chk("fs_ready_after", 32'(col_ready), 32'(b == 7 ? 0 : 1));
    end
    wait_done(200);
    chk("fs_count", 32'(move_count), 32'(64));

    // Backpressure: 24 moves into a 16-deep FIFO
    ready_fixed = 1'b0;
    tick();
    do_start();
    for (int b = 0; b < 3; b++) send_beat(8'hFF, rnd_moves(), b == 2);
    for (int j = 0; j < 10; j++) tick();
    chk("bp_col_ready", 32'(col_ready), 32'(0));
    chk("bp_valid", 32'(mv_valid), 32'(1));
    chk("bp_head", 32'(mv_data), 32'(exp_q[0]));
    chk("bp_count", 32'(move_count), 32'(16));
    ready_fixed = 1'b1;
    wait_done(300);
    chk("bp_count_end", 32'(move_count), 32'(24));

    // Empty columns
    do_start();
    p0 = n_pops; v0 = valid_cnt;
    for (int b = 0; b < 8; b++) send_beat(8'h00, rnd_moves(), b == 7);
    chk("ec_done_e0", 32'(scan_done), 32'(0));
    tick();
    chk("ec_done_e1", 32'(scan_done), 32'(1));
    tick();
    chk("ec_done_e2", 32'(scan_done), 32'(0));
    chk("ec_count", 32'(move_count), 32'(0));
    chk("ec_valid_cycles", 32'(valid_cnt - v0), 32'(0));
    chk("ec_pops", 32'(n_pops - p0), 32'(0));

    // Saturation: 260 moves with random backpressure
    rand_ready = 1'b1;
    do_start();
    p0 = n_pops;
    for (int b = 0; b < 33; b++) begin
      if (b == 31) begin
        wait_ready();
        chk("sat_ovf_248", 32'(overflow), 32'(0));
        chk("sat_cnt_248", 32'(move_count), 32'(248));
      end
      if (b == 32) begin
        wait_ready();
        chk("sat_ovf_256", 32'(overflow), 32'(1));
        chk("sat_cnt_256", 32'(move_count), 32'(255));
      end
      send_beat(b == 32 ? 8'h0F : 8'hFF, rnd_moves(), b == 32);
    end
    wait_done(2000);
    chk("sat_count", 32'(move_count), 32'(255));
    chk("sat_overflow", 32'(overflow), 32'(1));
    chk("sat_pops", 32'(n_pops - p0), 32'(260));

    // Randomized multi-beat scans
    for (int s = 0; s < 4; s++) begin
      int nb = $urandom_range(1, 8);
      do_start();
      for (int b = 0; b < nb; b++) send_beat(8'($urandom), rnd_moves(), b == nb - 1);
      wait_done(1000);
      chk("rnd_count", 32'(move_count), 32'(exp_count()));
      chk("rnd_overflow", 32'(overflow), 32'(0));
    end
    rand_ready = 1'b0;

    // Abort mid-SERIALIZE with 5 moves queued
    ready_fixed = 1'b0;
    tick();
    do_start();
    send_beat(8'hFF, rnd_moves(), 1'b0);
    for (int j = 0; j < 5; j++) tick();
    chk("ab_queued", 32'(move_count), 32'(5));
    d0 = done_cnt;
    do_start();
    chk("ab_valid", 32'(mv_valid), 32'(0));
    chk("ab_count", 32'(move_count), 32'(0));
    chk("ab_col_ready", 32'(col_ready), 32'(1));
    for (int j = 0; j < 3; j++) tick();
    chk("ab_still_accept", 32'(col_ready), 32'(1));
    chk("ab_no_done", 32'(done_cnt - d0), 32'(0));
    ready_fixed = 1'b1;
    send_beat(8'h03, rnd_moves(), 1'b1);
    wait_done(100);
    chk("ab_count_after", 32'(move_count), 32'(2));

    // Reset mid-scan
    ready_fixed = 1'b0;
    tick();
    do_start();
    send_beat(8'hFF, rnd_moves(), 1'b0);
    for (int j = 0; j < 3; j++) tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("mrst");
    reset = 1'b0;
    exp_q.delete();
    total = 0;
    tick();
    chk("mrst_idle", 32'(col_ready), 32'(0));
    ready_fixed = 1'b1;
    do_start();
    send_beat(8'h81, rnd_moves(), 1'b1);
    wait_done(100);
    chk("mrst_recover", 32'(move_count), 32'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
